rect_fill: RTL and testbench
============================

# rect_fill

Parametrised raster fill engine for the VGA frame buffer: on a start request it walks every pixel of a caller-supplied rectangle in row-major order and emits one pixel write per accepted beat, with a caller-supplied colour. It is the general successor to the full-screen clear. A full clear is the special case of the rectangle (0,0)–(WIDTH-1,HEIGHT-1). Compared with the clear, it adds a start/busy/done handshake, write backpressure, abort, bounds clamping and multi-bit colour. It sits between the drawing control FSM and the VGA frame-buffer write port.

## Interface
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- COORD_W, 11, coordinate width; must hold WIDTH-1 and HEIGHT-1
- COLOR_W, 1, pixel colour width

- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a fill; sampled only in IDLE
- abort  in  1  cancel a fill in progress
- x0, y0  in  COORD_W  top-left corner, inclusive
- x1, y1  in  COORD_W  bottom-right corner, inclusive
- color_in  in  COLOR_W  fill colour
- pixel_ready  in  1  frame buffer accepts a write this cycle
- pixel_write  out  1  x/y/pixel_color valid
- x, y  out  COORD_W  current pixel coordinate
- pixel_color  out  COLOR_W  colour of the current pixel
- busy  out  1  high in FILL
- done  out  1  one-cycle pulse when a fill completes

## Operation
- States: IDLE, FILL, DONE.
- Reset value of every output is 0, and the state returns to IDLE.
- **IDLE:**
  - On start, latch color_in and the bounds.
  - Clamp x1 to WIDTH-1 and y1 to HEIGHT-1. Clamp x0 and y0 the same way.
  - Load x=x0, y=y0, then go to FILL.
  - If the latched x0>x1 or y0>y1, the rectangle is empty: go straight to DONE with no writes.
- **FILL:**
  - pixel_write=1 and busy=1.
  - A beat is accepted when pixel_write && pixel_ready.
  - On an accepted beat:
    - if x==x1 and y==y1, go to DONE;
    - else if x==x1, set x=x0 and y=y+1;
    - else set x=x+1.
  - Without pixel_ready, x, y and pixel_color hold.
- **DONE:** done=1 for exactly one cycle, then go to IDLE.
- abort in FILL: go to IDLE next cycle. No done pulse; any pending beat is dropped.
- abort in IDLE or DONE has no effect.
- start while busy or in DONE is ignored. Inputs change only on start acceptance.
- reset mid-fill: return to IDLE next edge, all outputs 0, no done pulse.
- Arithmetic is unsigned and COORD_W wide. Counters never exceed the latched x1/y1, so there is no wrap-around.

## Timing
- start sampled at edge N: pixel_write is high from cycle N+1 with x=x0, y=y0.
- With pixel_ready held high, one pixel per cycle. A fill of w×h pixels gives pixel_write for w·h cycles, then done for 1 cycle.
  - Start-to-done latency is w·h+1 cycles.
- An empty rectangle gives done at cycle N+1.
- busy falls in the same cycle that done rises.
- A new start is accepted in the cycle after done at the earliest.
- Outputs are registered; no combinational path from pixel_ready to x, y or pixel_color.

## Structure
- Package rect_fill_pkg holds:
  - the state enum (IDLE, FILL, DONE);
  - a coord_t typedef of COORD_W bits;
  - the clamp function.
- One sub-module, raster_counter:
  - holds x/y with load (x0, y0), advance, and bounds x0/x1/y1;
  - outputs a last flag;
  - the top module keeps the FSM and handshake.

## Test plan
- Full screen, pixel_ready=1, (0,0)–(639,479), colour 1 → 307200 writes in row-major order, last write (639,479), done at cycle 307201.
- Rectangle (10,5)–(12,6), pixel_ready toggled 1/0 → exactly 6 writes: (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); coordinates hold on ready=0.
- Bounds (630,470)–(700,500) → clamped to (630..639, 470..479), 100 writes, done once.
- Empty rect x0=20, x1=10 → no pixel_write, done high at cycle N+1, busy never high.
- abort after 3 accepted beats → next cycle IDLE, busy=0, no done. A start asserted during FILL is ignored.
- reset asserted mid-fill → all outputs 0 next edge; a following start begins cleanly at (x0,y0).

Source files
------------

// File: rtl/rect_fill_pkg.sv
// Shared types for the rectangle fill engine: FSM states, coordinate type, clamp helper.
package rect_fill_pkg;

  localparam int COORD_W_DFLT = 11;

  typedef logic [COORD_W_DFLT-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/rect_fill_raster.sv
// Row-major x/y walker over a latched rectangle; last flags the bottom-right pixel.
module raster_counter #(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0_in,
  input  logic [COORD_W-1:0] y0_in,
  input  logic [COORD_W-1:0] x1_in,
  input  logic [COORD_W-1:0] y1_in,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (load) begin
      x_d  = x0_in;
      y_d  = y0_in;
      x0_d = x0_in;
      x1_d = x1_in;
      y1_d = y1_in;
    end else if (advance) begin
      if (x_q == x1_q) begin
        x_d = x0_q;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/rect_fill.sv
// Raster rectangle fill: start/busy/done handshake, one pixel per accepted beat, abort.
// Outputs decode from registers only; pixel_ready steers next-state logic, never outputs.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COORD_W = 11,
  parameter int COLOR_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               pixel_ready,
  output logic               pixel_write,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COORD_W-1:0] x0_c, y0_c, x1_c, y1_c;
  logic               empty, load, advance, last;

  always_comb begin
    x0_c  = COORD_W'(clamp(32'(x0), 32'(WIDTH - 1)));
    x1_c  = COORD_W'(clamp(32'(x1), 32'(WIDTH - 1)));
    y0_c  = COORD_W'(clamp(32'(y0), 32'(HEIGHT - 1)));
    y1_c  = COORD_W'(clamp(32'(y1), 32'(HEIGHT - 1)));
    empty = (x0_c > x1_c) || (y0_c > y1_c);
  end

  always_comb begin
    state_d = state_q;
    color_d = color_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          color_d = color_in;
          state_d = empty ? DONE : FILL;
        end
      end
      FILL: begin
        // Abort wins over a beat accepted in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (pixel_ready) begin
          if (last) state_d = DONE;
          else      advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
    end
  end

  raster_counter #(.COORD_W(COORD_W)) u_raster (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .x0_in   (x0_c),
    .y0_in   (y0_c),
    .x1_in   (x1_c),
    .y1_in   (y1_c),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  assign pixel_write = (state_q == FILL);
  assign busy        = (state_q == FILL);
  assign done        = (state_q == DONE);
  assign pixel_color = color_q;

endmodule

// File: tb/tb_rect_fill.sv
// Randomised scoreboard bench for rect_fill on a reduced 64x48 screen.
module tb_rect_fill;
  import rect_fill_pkg::*;

  localparam int W  = 64;
  localparam int H  = 48;
  localparam int CW = 11;
  localparam int KW = 4;

  typedef struct {
    int x;
    int y;
    int c;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, pixel_ready;
  coord_t        x0, y0, x1, y1;
  logic [KW-1:0] color_in;
  logic          pixel_write, busy, done;
  coord_t        x, y;
  logic [KW-1:0] pixel_color;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;
  logic  hold_pend = 1'b0;
  int    hx, hy, hc;

  rect_fill #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .COLOR_W(KW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .color_in    (color_in),
    .pixel_ready (pixel_ready),
    .pixel_write (pixel_write),
    .x           (x),
    .y           (y),
    .pixel_color (pixel_color),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every accepted beat is popped from the scoreboard; stalled beats must hold.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && pixel_write) begin
        checks++;
        if (int'(x) != hx || int'(y) != hy || int'(pixel_color) != hc) begin
          failures++;
          $display("FAIL hold: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   x, y, pixel_color, hx, hy, hc);
        end
      end
      hold_pend = pixel_write && !pixel_ready && !abort;
      hx = int'(x);
      hy = int'(y);
      hc = int'(pixel_color);
      if (pixel_write && pixel_ready && !abort) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat: got unexpected write (%0d,%0d,%0d) expected none", x, y, pixel_color);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (int'(x) != e.x || int'(y) != e.y || int'(pixel_color) != e.c) begin
            failures++;
            $display("FAIL beat: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     x, y, pixel_color, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  // mode 0: ready always high, 1: toggling, 2: random.
  // abort_after/reset_after >= 0 interrupt the fill once that many beats were accepted.
  task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int mode, input int abort_after,
                          input int reset_after);
    int    cx0, cy0, cx1, cy1, n, k, limit, dseen, bseen;
    bit    empty, got_done, stopped, tog;
    beat_t b;
    cx0   = (ax0 > W - 1) ? W - 1 : ax0;
    cx1   = (ax1 > W - 1) ? W - 1 : ax1;
    cy0   = (ay0 > H - 1) ? H - 1 : ay0;
    cy1   = (ay1 > H - 1) ? H - 1 : ay1;
    empty = (cx0 > cx1) || (cy0 > cy1);
    n     = empty ? 0 : (cx1 - cx0 + 1) * (cy1 - cy0 + 1);
    if (!empty)
      for (int yy = cy0; yy <= cy1; yy++)
        for (int xx = cx0; xx <= cx1; xx++) begin
          b.x = xx; b.y = yy; b.c = col;
          exp_q.push_back(b);
        end
    beats       = 0;
    bseen       = 0;
    x0          = CW'(ax0);
    y0          = CW'(ay0);
    x1          = CW'(ax1);
    y1          = CW'(ay1);
    color_in    = KW'(col);
    start       = 1'b1;
    tog         = 1'b1;
    pixel_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k        = 0;
    got_done = 1'b0;
    stopped  = 1'b0;
    limit    = n * 8 + 20;
    while (!got_done && !stopped) begin
      @(negedge clk);
      k++;
      if (busy) bseen = 1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (k > limit) begin
        chk("done_timeout", k, limit);
        stopped = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      tog = ~tog;
      case (mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = tog;
        default: pixel_ready = ($urandom % 4) != 0;
      endcase
      if (abort_after >= 0 && beats == abort_after) begin
        abort = 1'b1;
        start = 1'b1;
        x0    = '0;
        y0    = '0;
        @(posedge clk);
        #1 abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_write", int'(pixel_write), 0);
        dseen = 0;
        bseen = 0;
        repeat (4) begin
          @(negedge clk);
          if (done) dseen++;
          if (busy) bseen++;
        end
        chk("abort_no_done", dseen, 0);
        chk("abort_start_ignored", bseen, 0);
        chk("abort_beats", beats, abort_after);
        @(posedge clk);
        #1;
        stopped = 1'b1;
      end else if (reset_after >= 0 && beats == reset_after) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outputs", int'({pixel_write, busy, done, x, y, pixel_color}), 0);
        reset = 1'b0;
        exp_q.delete();
        stopped = 1'b1;
      end
    end
    if (got_done) begin
      chk("done_busy_low", int'(busy), 0);
      chk("leftover_beats", exp_q.size(), 0);
      chk("beat_count", beats, n);
      if (mode == 0) chk("done_latency", k, n + 1);
      if (empty) chk("empty_busy_seen", bseen, 0);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    pixel_ready = 1'b0;
    x0          = '0;
    y0          = '0;
    x1          = '0;
    y1          = '0;
    color_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({pixel_write, busy, done, x, y, pixel_color}), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_fill(0, 0, W - 1, H - 1, 1, 0, -1, -1);       // full screen
    run_fill(10, 5, 12, 6, 9, 1, -1, -1);             // small rect, toggled ready
    run_fill(60, 40, 100, 120, 6, 0, -1, -1);         // clamp to 60..63 x 40..47
    run_fill(2000, 45, 2047, 2000, 3, 0, -1, -1);     // clamp to single column
    run_fill(20, 0, 10, 5, 7, 0, -1, -1);             // empty: x0 > x1
    run_fill(3, 9, 8, 4, 7, 0, -1, -1);               // empty: y0 > y1
    run_fill(4, 4, 20, 10, 11, 2, 3, -1);             // abort after 3 beats
    run_fill(1, 1, 30, 9, 13, 2, -1, 5);              // reset mid-fill
    run_fill(7, 2, 9, 3, 14, 0, -1, -1);              // clean restart afterwards
    for (int i = 0; i < 12; i++) begin
      rx0 = int'($urandom_range(40, 75));
      rx1 = rx0 + int'($urandom_range(0, 8)) - 1;
      ry0 = int'($urandom_range(30, 55));
      ry1 = ry0 + int'($urandom_range(0, 8)) - 1;
      run_fill(rx0, ry0, rx1, ry1, int'($urandom_range(0, 15)), 2, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
